// File: rtl/univ_shift_pkg.sv
// Shared mode codes for the universal shift register, used by the RTL and its bench.
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_SHL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

endpackage

// File: rtl/shift_pipe.sv
// Output delay line: STAGES registers of data plus a valid bit, advancing every clock.
// STAGES=0 collapses to a straight wire.
module shift_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q       = d;
            assign q_valid = d_valid;
        end else begin : g_stages
            logic [WIDTH-1:0]  data_q [STAGES];
            logic [STAGES-1:0] valid_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < STAGES; k++) begin
                        data_q[k] <= '0;
                    end
                    valid_q <= '0;
                end else begin
                    data_q[0]  <= d;
                    valid_q[0] <= d_valid;
                    for (int k = 1; k < STAGES; k++) begin
                        data_q[k]  <= data_q[k-1];
                        valid_q[k] <= valid_q[k-1];
                    end
                end
            end

            assign q       = data_q[STAGES-1];
            assign q_valid = valid_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/shift/rotate/clear core with serial taps, followed by
// a DEPTH-1 stage output delay line carrying a per-result valid bit.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in_r,
    input  logic             s_in_l,
    output logic [WIDTH-1:0] p_out,
    output logic             s_out_r,
    output logic             s_out_l,
    output logic             valid_out
);

    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_d;
    logic             core_valid_q;
    logic             op_valid;

    always_comb begin
        core_d   = core_q;
        op_valid = 1'b0;
        if (en) begin
            case (mode)
                MODE_LOAD: begin
                    core_d   = p_in;
                    op_valid = 1'b1;
                end
                MODE_SHR: begin
                    core_d   = {s_in_r, core_q[WIDTH-1:1]};
                    op_valid = 1'b1;
                end
                MODE_SHL: begin
                    core_d   = {core_q[WIDTH-2:0], s_in_l};
                    op_valid = 1'b1;
                end
                MODE_ROR: begin
                    core_d   = {core_q[0], core_q[WIDTH-1:1]};
                    op_valid = 1'b1;
                end
                MODE_ROL: begin
                    core_d   = {core_q[WIDTH-2:0], core_q[WIDTH-1]};
                    op_valid = 1'b1;
                end
                MODE_CLR: begin
                    core_d   = '0;
                    op_valid = 1'b1;
                end
                default: begin
                    core_d   = core_q;
                    op_valid = 1'b0;
                end
            endcase
        end
    end

    // The valid bit is rewritten every edge so idle cycles launch a zero into the pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_q       <= '0;
            core_valid_q <= 1'b0;
        end else begin
            core_q       <= core_d;
            core_valid_q <= op_valid;
        end
    end

    assign s_out_r = core_q[0];
    assign s_out_l = core_q[WIDTH-1];

    shift_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (DEPTH - 1)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .d       (core_q),
        .d_valid (core_valid_q),
        .q       (p_out),
        .q_valid (valid_out)
    );

endmodule
